sampswitch_ctrl: RTL and testbench

Parametrised digital timing generator that drives the gate controls of NCH sampling-switch pairs (top-plate and bottom-plate) in the ADC front end. Channels are sampled in round-robin order. Each conversion tracks for a programmable number of cycles, opens the bottom-plate switch first, then opens the top-plate switch after a programmable non-overlap gap. The held sample is then offered to the converter over a valid/ready handshake. It replaces fixed, single-switch clocking with per-channel, programmable bottom-plate sampling.

---
 rtl/sampswitch_pkg.sv | 30 +++
 rtl/sampswitch_rr_pick.sv | 37 +++
 rtl/sampswitch_ctrl.sv | 129 ++++++++++++
 tb/tb_sampswitch_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampswitch_pkg.sv
// ============================================================================
// sampswitch_pkg : shared state encoding and defaults for sampswitch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package sampswitch_pkg;

    localparam int NCH_DEF  = 4;
    localparam int CNTW_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_NOVL  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        TRACK = ST_TRACK,
        NOVL  = ST_NOVL,
        HOLD  = ST_HOLD
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sampswitch_rr_pick.sv
// ============================================================================
// sampswitch_rr_pick : first set mask bit at or after ptr, wrapping
// Rev 1.0
// ============================================================================
`default_nettype none

module sampswitch_rr_pick
    import sampswitch_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] mask,
    input  logic [IW-1:0]  ptr,
    output logic [IW-1:0]  idx,
    output logic           found
);

    logic [IW-1:0] j;

    // Scan from the far end down so the nearest candidate is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NCH);
            if (mask[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sampswitch_ctrl.sv
// ============================================================================
// sampswitch_ctrl : round-robin bottom-plate sampling switch timing generator
// Rev 1.0
// ============================================================================
`default_nettype none

module sampswitch_ctrl
    import sampswitch_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NCH-1:0]              ch_mask,
    input  logic [CNTW-1:0]             track_cycles,
    input  logic [CNTW-1:0]             novl_cycles,
    output logic [NCH-1:0]              samp_top,
    output logic [NCH-1:0]              samp_bot,
    output logic                        hold_valid,
    output logic [idx_width(NCH)-1:0]   hold_ch,
    input  logic                        hold_ready,
    output logic                        busy
);

    localparam int            IW   = idx_width(NCH);
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] novl_lat;
    logic [IW-1:0]   ch;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   next_ptr;
    logic [IW-1:0]   pick_ptr;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;

    function automatic logic [CNTW-1:0] len_m1(input logic [CNTW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // On acceptance the picker must already see the advanced pointer.
    assign next_ptr = (ch == LAST) ? '0 : ch + 1'b1;
    assign pick_ptr = (state == HOLD) ? next_ptr : ptr;
    assign busy     = (state != IDLE);

    sampswitch_rr_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .mask  (ch_mask),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            novl_lat   <= '0;
            ch         <= '0;
            ptr        <= '0;
            samp_top   <= '0;
            samp_bot   <= '0;
            hold_valid <= 1'b0;
            hold_ch    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && pick_found) begin
                        state    <= TRACK;
                        ch       <= pick_idx;
                        cnt      <= len_m1(track_cycles);
                        novl_lat <= novl_cycles;
                        samp_top <= onehot(pick_idx);
                        samp_bot <= onehot(pick_idx);
                    end
                end
                TRACK: begin
                    if (cnt == '0) begin
                        state    <= NOVL;
                        cnt      <= len_m1(novl_lat);
                        samp_bot <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                NOVL: begin
                    if (cnt == '0) begin
                        state      <= HOLD;
                        samp_top   <= '0;
                        hold_valid <= 1'b1;
                        hold_ch    <= ch;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_ready) begin
                        hold_valid <= 1'b0;
                        ptr        <= next_ptr;
                        if (en && pick_found) begin
                            state    <= TRACK;
                            ch       <= pick_idx;
                            cnt      <= len_m1(track_cycles);
                            novl_lat <= novl_cycles;
                            samp_top <= onehot(pick_idx);
                            samp_bot <= onehot(pick_idx);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sampswitch_ctrl.sv
// ============================================================================
// tb_sampswitch_ctrl : self-checking bench for sampswitch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sampswitch_ctrl;

    localparam int NCH  = 4;
    localparam int CNTW = 8;

    logic            clk          = 1'b0;
    logic            rst_n        = 1'b0;
    logic            en           = 1'b0;
    logic            hold_ready   = 1'b0;
    logic [NCH-1:0]  ch_mask      = '0;
    logic [CNTW-1:0] track_cycles = '0;
    logic [CNTW-1:0] novl_cycles  = '0;
    logic [NCH-1:0]  samp_top;
    logic [NCH-1:0]  samp_bot;
    logic            hold_valid;
    logic [1:0]      hold_ch;
    logic            busy;

    always #5 clk = ~clk;

    sampswitch_ctrl #(
        .NCH  (NCH),
        .CNTW (CNTW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .ch_mask      (ch_mask),
        .track_cycles (track_cycles),
        .novl_cycles  (novl_cycles),
        .samp_top     (samp_top),
        .samp_bot     (samp_bot),
        .hold_valid   (hold_valid),
        .hold_ch      (hold_ch),
        .hold_ready   (hold_ready),
        .busy         (busy)
    );

    typedef struct {
        logic [NCH-1:0]  mask;
        logic [CNTW-1:0] track;
        logic [CNTW-1:0] novl;
        int              nsamp;
        int              period;
    } vec_t;

    int             n_chk      = 0;
    int             n_fail     = 0;
    int             exp_q[$];
    int             exp_both   = 1;
    int             exp_top    = 1;
    int             exp_period = 0;
    logic [NCH-1:0] exp_mask   = '1;
    int             both_cnt   = 0;
    int             top_cnt    = 0;
    int             cyc        = 0;
    int             last_acc   = -1;
    logic           prev_hv    = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int model_next(input logic [NCH-1:0] m, input int p);
        int c;
        for (int k = 0; k < NCH; k++) begin
            c = (p + k) % NCH;
            if (m[c[1:0]]) return c;
        end
        return -1;
    endfunction

    // Monitor: switch invariants, phase lengths, period and scoreboard pop.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            both_cnt = 0;
            top_cnt  = 0;
            prev_hv  = 1'b0;
        end else begin
            chk("bot_implies_top", int'(samp_bot & ~samp_top), 0);
            chk("single_channel", int'($countones(samp_top) > 1), 0);
            chk("masked_channel", int'(samp_top & ~exp_mask), 0);
            if (hold_valid) chk("hold_switches_open", int'(samp_top | samp_bot), 0);
            if (samp_top != '0 && samp_bot != '0) both_cnt++;
            else if (samp_top != '0) top_cnt++;
            if (hold_valid && !prev_hv) begin
                chk("track_len", both_cnt, exp_both);
                chk("novl_len", top_cnt, exp_top);
                both_cnt = 0;
                top_cnt  = 0;
            end
            prev_hv = hold_valid;
            if (hold_valid && hold_ready) begin
                if (exp_q.size() == 0) chk("extra_hold", 1, 0);
                else chk("hold_ch", int'(hold_ch), exp_q.pop_front());
                if (exp_period > 0 && last_acc >= 0) chk("period", cyc - last_acc, exp_period);
                last_acc = cyc;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        en         = 1'b0;
        hold_ready = 1'b0;
        exp_q.delete();
        last_acc   = -1;
        both_cnt   = 0;
        top_cnt    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_q_le(input int target, input string nm);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() <= target) break;
            @(posedge clk);
        end
        if (exp_q.size() > target) chk(nm, exp_q.size(), target);
    endtask

    task automatic set_cfg(input logic [NCH-1:0] m, input logic [CNTW-1:0] t,
                           input logic [CNTW-1:0] n, input int per);
        ch_mask      = m;
        track_cycles = t;
        novl_cycles  = n;
        exp_mask     = m;
        exp_both     = (t == 0) ? 1 : int'(t);
        exp_top      = (n == 0) ? 1 : int'(n);
        exp_period   = per;
    endtask

    vec_t vecs[5];
    int   p;
    int   c;
    bit   seen;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b1111, 8'd5, 8'd2, 5, 8};
        vecs[1] = '{4'b1010, 8'd3, 8'd1, 4, 5};
        vecs[2] = '{4'b1111, 8'd0, 8'd0, 4, 3};
        vecs[3] = '{4'b0001, 8'd1, 8'd3, 3, 5};
        vecs[4] = '{4'b0100, 8'd2, 8'd0, 2, 4};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_top", int'(samp_top), 0);
        chk("rst_bot", int'(samp_bot), 0);
        chk("rst_hold_valid", int'(hold_valid), 0);
        chk("rst_hold_ch", int'(hold_ch), 0);
        chk("rst_busy", int'(busy), 0);

        // Table-driven free-running sequences with hold_ready tied high
        foreach (vecs[v]) begin
            do_reset();
            set_cfg(vecs[v].mask, vecs[v].track, vecs[v].novl, vecs[v].period);
            hold_ready = 1'b1;
            p = 0;
            for (int s = 0; s < vecs[v].nsamp; s++) begin
                c = model_next(vecs[v].mask, p);
                exp_q.push_back(c);
                p = (c + 1) % NCH;
            end
            en = 1'b1;
            wait_q_le(1, "vec_wait_last");
            @(posedge clk);
            #1;
            en = 1'b0;
            wait_q_le(0, "vec_wait_done");
            repeat (3) @(posedge clk);
            #1;
            chk("vec_idle_busy", int'(busy), 0);
            chk("vec_idle_top", int'(samp_top), 0);
        end

        // Backpressure
        do_reset();
        set_cfg(4'b1111, 8'd2, 8'd1, 0);
        exp_q.push_back(0);
        exp_q.push_back(1);
        en   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (hold_valid) seen = 1'b1;
        end
        chk("bp_hold_reached", int'(seen), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(hold_valid), 1);
            chk("bp_ch", int'(hold_ch), 0);
            chk("bp_switches", int'(samp_top | samp_bot), 0);
        end
        @(posedge clk);
        #1;
        hold_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_fall", int'(hold_valid), 0);
        chk("bp_next_top", int'(samp_top), 2);
        chk("bp_next_bot", int'(samp_bot), 2);
        en = 1'b0;
        wait_q_le(0, "bp_wait_done");
        repeat (3) @(posedge clk);
        #1;
        chk("bp_idle_busy", int'(busy), 0);

        // Mid-run changes during NOVL
        do_reset();
        set_cfg(4'b1111, 8'd3, 8'd4, 0);
        hold_ready = 1'b1;
        exp_q.push_back(0);
        en   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (samp_top != '0 && samp_bot == '0) seen = 1'b1;
        end
        chk("mid_novl_reached", int'(seen), 1);
        en           = 1'b0;
        ch_mask      = 4'b1001;
        track_cycles = 8'd7;
        novl_cycles  = 8'd7;
        wait_q_le(0, "mid_wait_done");
        repeat (3) @(posedge clk);
        #1;
        chk("mid_idle_busy", int'(busy), 0);
        chk("mid_idle_valid", int'(hold_valid), 0);
        exp_both = 7;
        exp_top  = 7;
        exp_mask = 4'b1001;
        exp_q.push_back(3);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        chk("resume_top", int'(samp_top), 8);
        wait_q_le(0, "resume_wait_done");
        repeat (3) @(posedge clk);
        #1;
        chk("resume_idle_busy", int'(busy), 0);

        // Asynchronous reset mid-TRACK
        do_reset();
        set_cfg(4'b1111, 8'd10, 8'd1, 0);
        hold_ready = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) @(negedge clk);
        chk("pre_rst_bot", int'(samp_bot), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_top", int'(samp_top), 0);
        chk("arst_bot", int'(samp_bot), 0);
        chk("arst_valid", int'(hold_valid), 0);
        chk("arst_busy", int'(busy), 0);
        both_cnt = 0;
        top_cnt  = 0;
        en       = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_top", int'(samp_top), 0);
        exp_q.push_back(0);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        wait_q_le(0, "post_rst_wait_done");
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
